// File: rtl/ins_mem_loader.sv
// ins_mem_loader: streams 32-bit instruction words into a byte-wide, big-endian instruction memory
// Ports: CLK/Reset (sync, active-low); start pulse begins a load at byte 0;
//   in_valid/in_ready/in_word/in_last form the word stream; mem_we/mem_addr/mem_wdata
//   drive the memory write port, mem_rdata is its combinational read byte;
//   InsMemRW=1 while the loader owns the memory; loading/done/word_count report progress;
//   err_overflow and err_verify are sticky error flags.
// Optional feature: define INS_MEM_LOADER_VERIFY_EN to read back and compare every word
//   after it is written (err_verify is constant 0 otherwise).
module ins_mem_loader #(
  parameter int MEM_BYTES = 128,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  input  logic             in_last,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  output logic             InsMemRW,
  output logic             loading,
  output logic             done,
  output logic [CNT_W-1:0] word_count,
  output logic             err_overflow,
  output logic             err_verify
);
`ifdef INS_MEM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, VERIFY} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign err_verify = 1'b0;
`endif
  localparam logic [31:0] LAST_PTR = 32'(MEM_BYTES - 4);
  state_t      state;
  logic [31:0] ptr;
  logic [1:0]  idx;
  logic [31:0] word_q;
  logic        last_q;
  // big-endian byte select: index 0 is bits [31:24]
  function automatic logic [7:0] sel(input logic [31:0] w, input logic [1:0] i);
    logic [31:0] s;
    s = w >> {~i, 3'b000};
    return s[7:0];
  endfunction
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state        <= IDLE;
      ptr          <= '0;
      idx          <= '0;
      word_q       <= '0;
      last_q       <= 1'b0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      InsMemRW     <= 1'b0;
      loading      <= 1'b0;
      done         <= 1'b0;
      word_count   <= '0;
      err_overflow <= 1'b0;
`ifdef INS_MEM_LOADER_VERIFY_EN
      err_verify   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state        <= ACCEPT;
          ptr          <= '0;
          word_count   <= '0;
          done         <= 1'b0;
          err_overflow <= 1'b0;
`ifdef INS_MEM_LOADER_VERIFY_EN
          err_verify   <= 1'b0;
`endif
          InsMemRW     <= 1'b1;
          loading      <= 1'b1;
          in_ready     <= 1'b1;
        end
        ACCEPT: if (in_valid) begin
          word_q   <= in_word;
          last_q   <= in_last;
          in_ready <= 1'b0;
          // no room for a whole word: reject it before touching memory
          if (ptr > LAST_PTR) begin
            state        <= DONE;
            err_overflow <= 1'b1;
            done         <= 1'b1;
            loading      <= 1'b0;
            InsMemRW     <= 1'b0;
          end else begin
            state     <= WRITE;
            idx       <= 2'd0;
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= in_word[31:24];
          end
        end
        WRITE: if (idx != 2'd3) begin
          idx       <= idx + 2'd1;
          mem_addr  <= ptr + 32'(idx + 2'd1);
          mem_wdata <= sel(word_q, idx + 2'd1);
        end else begin
          mem_we <= 1'b0;
`ifdef INS_MEM_LOADER_VERIFY_EN
          state    <= VERIFY;
          idx      <= 2'd0;
          InsMemRW <= 1'b0;
          mem_addr <= ptr;
`else
          ptr        <= ptr + 32'd4;
          word_count <= word_count + 1'b1;
          if (last_q) begin
            state    <= DONE;
            done     <= 1'b1;
            loading  <= 1'b0;
            InsMemRW <= 1'b0;
          end else begin
            state    <= ACCEPT;
            in_ready <= 1'b1;
          end
`endif
        end
`ifdef INS_MEM_LOADER_VERIFY_EN
        VERIFY: begin
          if (mem_rdata != sel(word_q, idx)) err_verify <= 1'b1;
          if (idx != 2'd3) begin
            idx      <= idx + 2'd1;
            mem_addr <= ptr + 32'(idx + 2'd1);
          end else begin
            ptr        <= ptr + 32'd4;
            word_count <= word_count + 1'b1;
            if (last_q) begin
              state   <= DONE;
              done    <= 1'b1;
              loading <= 1'b0;
            end else begin
              state    <= ACCEPT;
              in_ready <= 1'b1;
              InsMemRW <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ins_mem_loader.sv
// tb_ins_mem_loader: directed scoreboard bench for ins_mem_loader
module tb_ins_mem_loader;
`ifdef INS_MEM_LOADER_VERIFY_EN
  localparam logic VE = 1'b1;
`else
  localparam logic VE = 1'b0;
`endif
  logic        CLK = 1'b0, Reset = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_ready, mem_we, InsMemRW, loading, done, err_overflow, err_verify;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [5:0]  word_count;
  logic [7:0]  mem [0:255];
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
  wr_t         sb[$];
  int          n_cmp = 0, n_err = 0;
  logic [31:0] ptr_m = '0;
  logic [7:0]  exp2 [0:7] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h22, 8'h00, 8'h04};

  always #5 CLK = ~CLK;

  ins_mem_loader #(.MEM_BYTES(128), .CNT_W(6)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .InsMemRW(InsMemRW), .loading(loading),
    .done(done), .word_count(word_count), .err_overflow(err_overflow), .err_verify(err_verify)
  );

  always @(posedge CLK) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  // readback path corrupts byte 2 so the verify feature has something to catch
  assign mem_rdata = (VE && mem_addr == 32'd2) ? ~mem[2] : mem[mem_addr[7:0]];

  function automatic logic [31:0] wv(input int i);
    return 32'h1020_3040 ^ (32'(i) * 32'h0101_0101);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_unexpected: observed write addr %0h data %0h expected none", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", {24'b0, mem_wdata}, {24'b0, e.d});
      end
    end
  end

  task automatic pulse_start;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_ready;
    int k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    if (k == 50) begin
      n_cmp++;
      n_err++;
      $error("FAIL wait_ready: observed in_ready %b expected 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic wait_done;
    int k = 0;
    while (done !== 1'b1 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    if (k == 50) begin
      n_cmp++;
      n_err++;
      $error("FAIL wait_done: observed done %b expected 1 within 50 cycles", done);
    end
  endtask

  // fits=1: word is expected to be written; fits=0: expected to be rejected by overflow
  task automatic send_word(input logic [31:0] w, input logic last, input logic fits);
    wait_ready();
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    if (fits) for (int b = 0; b < 4; b++) sb.push_back('{ptr_m + 32'(b), w[31-8*b -: 8]});
    @(posedge CLK);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
    if (fits) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge CLK);
        chk("write_we", {31'b0, mem_we}, 32'd1);
        chk("write_ready", {31'b0, in_ready}, 32'd0);
      end
      ptr_m += 32'd4;
    end else begin
      @(negedge CLK);
      chk("ovf_we", {31'b0, mem_we}, 32'd0);
      chk("ovf_flag", {31'b0, err_overflow}, 32'd1);
      chk("ovf_done", {31'b0, done}, 32'd1);
    end
  endtask

  initial begin
    logic [7:0] old2;
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
    chk("rst_insmemrw", {31'b0, InsMemRW}, 32'd0);
    chk("rst_loading", {31'b0, loading}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_word_count", {26'b0, word_count}, 32'd0);
    chk("rst_err_overflow", {31'b0, err_overflow}, 32'd0);
    chk("rst_err_verify", {31'b0, err_verify}, 32'd0);
    Reset = 1'b1;
    @(negedge CLK);
    chk("idle_in_ready", {31'b0, in_ready}, 32'd0);
    chk("idle_insmemrw", {31'b0, InsMemRW}, 32'd0);
    in_valid = 1'b1;
    pulse_start();
    in_valid = 1'b0;
    chk("start_insmemrw", {31'b0, InsMemRW}, 32'd1);
    chk("start_loading", {31'b0, loading}, 32'd1);
    chk("start_in_ready", {31'b0, in_ready}, 32'd1);
    chk("start_no_we", {31'b0, mem_we}, 32'd0);
    ptr_m = '0;
    send_word(32'h2001_0005, 1'b0, 1'b1);
    wait_ready();
    repeat (3) begin
      @(negedge CLK);
      chk("gap_in_ready", {31'b0, in_ready}, 32'd1);
      chk("gap_no_we", {31'b0, mem_we}, 32'd0);
    end
    send_word(32'hAC22_0004, 1'b1, 1'b1);
    wait_done();
    chk("t2_done", {31'b0, done}, 32'd1);
    chk("t2_insmemrw", {31'b0, InsMemRW}, 32'd0);
    chk("t2_loading", {31'b0, loading}, 32'd0);
    chk("t2_word_count", {26'b0, word_count}, 32'd2);
    chk("t2_err_overflow", {31'b0, err_overflow}, 32'd0);
    chk("t2_err_verify", {31'b0, err_verify}, {31'b0, VE});
    for (int i = 0; i < 8; i++) chk("t2_mem", {24'b0, mem[i]}, {24'b0, exp2[i]});
    pulse_start();
    chk("t4_start_count", {26'b0, word_count}, 32'd0);
    chk("t4_start_done", {31'b0, done}, 32'd0);
    ptr_m = '0;
    for (int i = 0; i < 32; i++) send_word(wv(i), 1'b0, 1'b1);
    send_word(32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("t4_word_count", {26'b0, word_count}, 32'd32);
    chk("t4_insmemrw", {31'b0, InsMemRW}, 32'd0);
    chk("t4_err_verify", {31'b0, err_verify}, {31'b0, VE});
    old2 = wv(0)[15:8];
    chk("t4_mem127", {24'b0, mem[127]}, {24'b0, wv(31)[7:0]});
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    pulse_start();
    chk("t5_ovf_cleared", {31'b0, err_overflow}, 32'd0);
    wait_ready();
    in_valid = 1'b1;
    in_word  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
    sb.push_back('{32'd0, 8'hDE});
    sb.push_back('{32'd1, 8'hAD});
    @(posedge CLK);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_byte1_addr", mem_addr, 32'd1);
    Reset = 1'b0;
    @(negedge CLK);
    chk("t5_no_we", {31'b0, mem_we}, 32'd0);
    chk("t5_loading", {31'b0, loading}, 32'd0);
    chk("t5_insmemrw", {31'b0, InsMemRW}, 32'd0);
    chk("t5_mem_addr", mem_addr, 32'd0);
    chk("t5_word_count", {26'b0, word_count}, 32'd0);
    chk("t5_mem0", {24'b0, mem[0]}, 32'hDE);
    chk("t5_mem1", {24'b0, mem[1]}, 32'hAD);
    chk("t5_mem2_kept", {24'b0, mem[2]}, {24'b0, old2});
    Reset = 1'b1;
    @(negedge CLK);
    pulse_start();
    ptr_m = '0;
    send_word(32'h0123_4567, 1'b1, 1'b1);
    wait_done();
    chk("t5_restart_count", {26'b0, word_count}, 32'd1);
    chk("t5_restart_mem3", {24'b0, mem[3]}, 32'h67);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ins_mem_loader.md
Name: ins_mem_loader

Overview:
- Writer side of the byte-addressed, big-endian instruction memory. It accepts 32-bit instruction words over a valid/ready stream and writes each word into the memory write port as four sequential bytes.
- While loading, it drives InsMemRW=1 so the memory is in write mode. On completion it releases InsMemRW=0 so the CPU can fetch.
- It sits between the boot/host link and the instruction memory.

Parameters:
- MEM_BYTES, 128: instruction memory size in bytes; must be a multiple of 4.
- CNT_W, 6: width of word_count; must be ≥ log2(MEM_BYTES/4)+1.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on the CLK rising edge.
- start  in  1  single-cycle pulse that begins a load at byte address 0.
- in_valid  in  1  in_word/in_last are valid.
- in_ready  out  1  loader can accept a word this cycle.
- in_word  in  32  instruction word; bits [31:24] go to the lowest byte address.
- in_last  in  1  marks the final word of the program.
- mem_we  out  1  byte write enable to the instruction memory.
- mem_addr  out  32  byte address to the memory.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  combinational read byte at mem_addr; used only with the optional feature.
- InsMemRW  out  1  1 = loader owns memory (write mode); 0 = CPU read mode.
- loading  out  1  load in progress.
- done  out  1  sticky load-complete flag.
- word_count  out  CNT_W  words fully written in the current load.
- err_overflow  out  1  sticky: a word arrived with no room left.
- err_verify  out  1  sticky readback mismatch; tied 0 without the optional feature.

Behaviour:
- Reset: Reset=0 at a rising edge forces state IDLE and sets every output to 0, including mem_addr and word_count.
  - Reset mid-load aborts immediately. The next cycle has no mem_we. Bytes already written stay in memory.
- States: IDLE, ACCEPT, WRITE, DONE, plus VERIFY with the optional feature. All outputs are registered.
- IDLE / DONE:
  - in_ready=0, mem_we=0, InsMemRW=0.
  - DONE holds done=1, loading=0.
  - start=1 → ACCEPT next cycle. This clears done, word_count, err_overflow and err_verify, and sets the write pointer ptr=0, InsMemRW=1, loading=1.
- ACCEPT:
  - in_ready=1. The handshake is in_valid & in_ready in the same cycle; the loader latches in_word and in_last.
  - If ptr > MEM_BYTES-4: set err_overflow=1, write nothing, go to DONE.
  - Otherwise go to WRITE with byte index idx=0.
- WRITE: four consecutive cycles with mem_we=1 and mem_addr=ptr+idx.
  - mem_wdata = in_word[31:24], [23:16], [15:8], [7:0] for idx=0..3.
  - in_ready=0 throughout.
  - After idx=3: ptr+=4, word_count+=1. If in_last → DONE, else → ACCEPT.
- Throughput: 5 cycles/word with in_valid held high. The first mem_we occurs the cycle after the handshake.
- start is ignored in ACCEPT, WRITE and VERIFY.
- in_valid is ignored in IDLE, DONE and WRITE (in_ready=0), including when start and in_valid are high in the same IDLE cycle.
- in_last on a word rejected by overflow still ends the load in DONE; the flag is irrelevant there.
- Address arithmetic is 32-bit and never wraps: overflow is detected before the write.

Optional Feature:
- Macro: INS_MEM_LOADER_VERIFY_EN.
- Defined:
  - After the 4th WRITE cycle, enter VERIFY for 4 cycles with mem_we=0, InsMemRW=0 and mem_addr=ptr+idx (idx 0..3).
  - Compare mem_rdata against the expected byte in the same cycle; any mismatch sets err_verify=1 (sticky).
  - Then ptr/word_count update, and the next state is chosen by in_last as above. Throughput becomes 9 cycles/word.
- Undefined: no VERIFY state; err_verify is constant 0; mem_rdata is unused.

Test Plan:
1. Reset=0 for 2 cycles, then 1 → all outputs 0, state IDLE. Pulse start → next cycle InsMemRW=1, loading=1, in_ready=1.
2. Load words 0x20010005, then 0xAC220004 with in_last → writes (addr,data):
   - (0,0x20), (1,0x01), (2,0x00), (3,0x05)
   - (4,0xAC), (5,0x22), (6,0x00), (7,0x04)
   - Then done=1, InsMemRW=0, word_count=2.
3. in_valid low for 3 cycles between words → loader waits in ACCEPT with in_ready=1 and no mem_we; the write sequence resumes correctly on the next handshake.
4. MEM_BYTES=128, feed 33 words with in_last only on the 33rd → 32 words written (last byte addr 127). On the 33rd word, err_overflow=1, no write, done=1, word_count=32.
5. Reset=0 during the 2nd byte of a word → no mem_we the following cycle, IDLE, bytes 0..1 retained. Pulse start → load restarts at addr 0.
6. With INS_MEM_LOADER_VERIFY_EN, the memory model corrupts byte addr 2 → err_verify=1 after the first word, load still completes, done=1.
